// File: rtl/divider_unit.sv
// Iterative 32/16 and 16/8 divider, signed or unsigned, one quotient bit per cycle.
// Faults (divide by zero, quotient overflow) report through error alongside complete.
module divider_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_8_bit,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        complete,
    output logic        error
);
    typedef enum logic [2:0] {IDLE, INIT, DIVIDE, FIXUP, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] dvd_reg;
    logic [15:0] dvs_reg;
    logic        is8_reg, sgn_reg;
    logic [15:0] rem_reg, low_reg;
    logic [3:0]  count_reg;
    logic [15:0] q_reg, r_reg;
    logic        err_reg;

    logic        accept;
    logic        dvd_neg, dvs_neg;
    logic [31:0] dvd_ext, dvd_negated, dvd_mag;
    logic [15:0] dvs_ext, dvs_negated, dvs_mag, dvd_high;
    logic        init_fault;
    logic [16:0] shifted, diff;
    logic        fits;
    logic [15:0] q_mag, q_fix, r_fix;
    logic        q_ovf;

    assign accept = start && (state_reg == IDLE || state_reg == DONE);

    // Operand magnitudes from the captured operands
    assign dvd_neg     = sgn_reg && (is8_reg ? dvd_reg[15] : dvd_reg[31]);
    assign dvs_neg     = sgn_reg && (is8_reg ? dvs_reg[7] : dvs_reg[15]);
    assign dvd_ext     = is8_reg ? {{16{dvd_reg[15]}}, dvd_reg[15:0]} : dvd_reg;
    assign dvs_ext     = is8_reg ? {{8{dvs_reg[7]}}, dvs_reg[7:0]} : dvs_reg;
    assign dvd_negated = 32'd0 - dvd_ext;
    assign dvs_negated = 16'd0 - dvs_ext;

    always_comb begin
        dvd_mag = is8_reg ? {16'd0, dvd_reg[15:0]} : dvd_reg;
        dvs_mag = is8_reg ? {8'd0, dvs_reg[7:0]} : dvs_reg;
        if (dvd_neg) dvd_mag = is8_reg ? {16'd0, dvd_negated[15:0]} : dvd_negated;
        if (dvs_neg) dvs_mag = is8_reg ? {8'd0, dvs_negated[7:0]} : dvs_negated;
    end

    // A high half not below the divisor cannot yield a quotient that fits
    assign dvd_high   = is8_reg ? {8'd0, dvd_mag[15:8]} : dvd_mag[31:16];
    assign init_fault = (dvs_mag == 16'd0) || (dvd_high >= dvs_mag);

    // Restoring step: partial remainder stays below the divisor, so 17 bits cover the shift
    assign shifted = {rem_reg, low_reg[15]};
    assign fits    = shifted >= {1'b0, dvs_mag};
    assign diff    = shifted - {1'b0, dvs_mag};

    // Sign fixup; an 8-bit quotient sits in low_reg[7:0] after its eight shifts
    assign q_mag = is8_reg ? {8'd0, low_reg[7:0]} : low_reg;
    assign q_ovf = sgn_reg && (is8_reg ? q_mag[7] : q_mag[15]);

    always_comb begin
        q_fix = (dvd_neg ^ dvs_neg) ? (16'd0 - q_mag) : q_mag;
        r_fix = dvd_neg ? (16'd0 - rem_reg) : rem_reg;
        if (is8_reg) begin
            q_fix = q_fix & 16'h00FF;
            r_fix = r_fix & 16'h00FF;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = INIT;
            INIT:    state_next = init_fault ? DONE : DIVIDE;
            DIVIDE:  if (count_reg == 4'd0) state_next = FIXUP;
            FIXUP:   state_next = DONE;
            DONE:    state_next = start ? INIT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            dvd_reg   <= '0;
            dvs_reg   <= '0;
            is8_reg   <= 1'b0;
            sgn_reg   <= 1'b0;
            rem_reg   <= '0;
            low_reg   <= '0;
            count_reg <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                dvd_reg <= dividend;
                dvs_reg <= divisor;
                is8_reg <= is_8_bit;
                sgn_reg <= is_signed;
                q_reg   <= '0;
                r_reg   <= '0;
                err_reg <= 1'b0;
            end
            case (state_reg)
                INIT: begin
                    if (init_fault) begin
                        err_reg <= 1'b1;
                    end else begin
                        rem_reg   <= dvd_high;
                        low_reg   <= is8_reg ? {dvd_mag[7:0], 8'd0} : dvd_mag[15:0];
                        count_reg <= is8_reg ? 4'd7 : 4'd15;
                    end
                end
                DIVIDE: begin
                    rem_reg   <= fits ? diff[15:0] : shifted[15:0];
                    low_reg   <= {low_reg[14:0], fits};
                    count_reg <= count_reg - 4'd1;
                end
                FIXUP: begin
                    if (q_ovf) begin
                        err_reg <= 1'b1;
                    end else begin
                        q_reg <= q_fix;
                        r_reg <= r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_reg == INIT) || (state_reg == DIVIDE) || (state_reg == FIXUP);
    assign complete  = (state_reg == DONE);
    assign quotient  = q_reg;
    assign remainder = r_reg;
    assign error     = err_reg;
endmodule

// File: doc/divider_unit.md
DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock; all state changes occur on the rising edge.
REQ-002 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The module SHALL have port start, input, 1 bit: request a division; sampled only while busy=0.
REQ-004 The module SHALL have port is_8_bit, input, 1 bit: 1 = 16/8 divide, 0 = 32/16 divide.
REQ-005 The module SHALL have port is_signed, input, 1 bit: 1 = IDIV (two's complement), 0 = DIV.
REQ-006 The module SHALL have port dividend, input, 32 bits: DX:AX operand; only [15:0] is used when is_8_bit=1.
REQ-007 The module SHALL have port divisor, input, 16 bits: only [7:0] is used when is_8_bit=1.
REQ-008 The module SHALL have port quotient, output, 16 bits: result quotient; [15:8]=0 in 8-bit mode.
REQ-009 The module SHALL have port remainder, output, 16 bits: result remainder; [15:8]=0 in 8-bit mode.
REQ-010 The module SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-011 The module SHALL have port complete, output, 1 bit: single-cycle pulse; results or error valid.
REQ-012 The module SHALL have port error, output, 1 bit: divide fault (INT 0 condition); valid while complete=1.

Function
REQ-013 The module SHALL capture all inputs on the edge where start=1 and busy=0 (call that cycle T), and SHALL ignore later input changes.
REQ-014 The FSM SHALL have states IDLE, INIT, DIVIDE, FIXUP and DONE, with transitions as follows:
- IDLE->INIT on accepted start.
- INIT->DONE on error, otherwise INIT->DIVIDE.
- DIVIDE->FIXUP after N iterations, where N=8 (8-bit) or 16 (16-bit).
- FIXUP->DONE.
- DONE->IDLE, or DONE->INIT if start=1 in DONE.
REQ-015 INIT SHALL form the magnitudes of the operands: two's-complement absolute values when is_signed=1, raw values otherwise.
REQ-016 INIT SHALL flag an error when the divisor magnitude is 0.
REQ-017 INIT SHALL flag an error when the high half of the dividend magnitude (bits [31:16], or [15:8] in 8-bit mode) is >= the divisor magnitude.
REQ-018 DIVIDE SHALL perform restoring division at one quotient bit per cycle, MSB first, for exactly N cycles.
REQ-019 FIXUP SHALL negate the quotient when the dividend and divisor signs differ, and SHALL give the remainder the sign of the dividend (signed mode only).
REQ-020 FIXUP SHALL flag an error when is_signed=1 and the quotient magnitude exceeds 0x7FFF (16-bit) or 0x7F (8-bit); -32768 and -128 are faults.
REQ-021 busy SHALL be 1 from T+1 until the cycle before complete, and 0 in the complete cycle.
REQ-022 On a successful divide, complete SHALL be 1 in cycle T+N+3, with quotient and remainder valid and error=0.
REQ-023 On an INIT fault, complete=1 and error=1 SHALL occur in cycle T+2; quotient and remainder SHALL then be 0.
REQ-024 On a FIXUP fault, complete=1 and error=1 SHALL occur in cycle T+N+3; quotient and remainder SHALL then be 0.
REQ-025 quotient, remainder and error SHALL hold their values after complete until the next accepted start reaches INIT.
REQ-026 start asserted while busy=1 SHALL be ignored: no queueing, and the running operation is unaffected.
REQ-027 start asserted in the complete cycle SHALL be accepted; the new operation's INIT SHALL occur in the next cycle.
REQ-028 complete SHALL never be high for two consecutive cycles for the same operation.

Reset
REQ-029 While reset=1, the FSM SHALL be IDLE and quotient, remainder, busy, complete and error SHALL all be 0, asynchronously.
REQ-030 Reset asserted mid-operation SHALL abort it with no complete pulse; the first start after reset deasserts SHALL be accepted normally.

Verification
REQ-031 The bench SHALL cover an unsigned 16-bit divide: dividend=0x00000064, divisor=0x0007 -> complete at T+19, quotient=0x000E, remainder=0x0002, error=0.
REQ-032 The bench SHALL cover a signed 8-bit divide: dividend=0xFFF9 (-7), divisor=0x02 -> complete at T+11, quotient=0x00FD, remainder=0x00FF, error=0.
REQ-033 The bench SHALL cover divide by zero: divisor=0, any dividend -> complete and error at T+2, quotient=remainder=0.
REQ-034 The bench SHALL cover overflow in both modes, with quotient=remainder=0 in each case:
- Unsigned: dividend=0x00010000, divisor=0x0001 -> error at T+2.
- Signed: dividend=0x00008000, divisor=0x0001 -> error at T+19.
REQ-035 The bench SHALL cover start during busy and back-to-back starts:
- start pulsed at T+5 of a 16-bit divide -> ignored; single complete at T+19.
- start held high in the complete cycle -> second operation's complete 19 cycles later.
REQ-036 The bench SHALL cover reset at T+8 of a 16-bit divide -> all outputs 0 immediately, no complete; a fresh 100/7 divide then passes as in REQ-031.
